// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared widths and FSM state encoding for gcd_engine.
package gcd_pkg;
  localparam int WIDTH  = 16;
  localparam int ITER_W = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;
endpackage

// File: rtl/gcd_datapath.sv
// rtl/gcd_datapath.sv - operand registers, subtractor, magnitude compare and zero detect.
module gcd_datapath #(
  parameter int WIDTH = gcd_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             sub_a,
  input  logic             sub_b,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             a_zero,
  output logic             b_zero,
  output logic [WIDTH-1:0] final_value
);
  import gcd_pkg::*;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  assign gt     = (a_q > b_q);
  assign eq     = (a_q == b_q);
  assign lt     = (a_q < b_q);
  assign a_zero = (a_q == '0);
  assign b_zero = (b_q == '0);

  // When A is zero the answer is B; otherwise A covers both the B==0 and A==B exits.
  assign final_value = a_zero ? b_q : a_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (load) begin
      a_q <= a_in;
      b_q <= b_in;
    end else begin
      if (sub_a) a_q <= a_q - b_q;
      if (sub_b) b_q <= b_q - a_q;
    end
  end
endmodule

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - subtractive GCD engine with IDLE/CALC/DONE control FSM.
// Optional subtraction counter output iter_cnt under GCD_ITER_COUNT_EN.
module gcd_engine #(
  parameter int WIDTH = gcd_pkg::WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WIDTH-1:0]            a_in,
  input  logic [WIDTH-1:0]            b_in,
  output logic                        ready,
  output logic                        done,
  output logic [WIDTH-1:0]            result
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [gcd_pkg::ITER_W-1:0]  iter_cnt
`endif
);
  import gcd_pkg::*;

  state_t           state;
  state_t           next_state;
  logic             load;
  logic             sub_a;
  logic             sub_b;
  logic             finish;
  logic             gt;
  logic             eq;
  logic             lt;
  logic             a_zero;
  logic             b_zero;
  logic [WIDTH-1:0] final_value;

  gcd_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .sub_a       (sub_a),
    .sub_b       (sub_b),
    .a_in        (a_in),
    .b_in        (b_in),
    .gt          (gt),
    .eq          (eq),
    .lt          (lt),
    .a_zero      (a_zero),
    .b_zero      (b_zero),
    .final_value (final_value)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_CALC;
      ST_CALC: if (a_zero || b_zero || eq) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Zero checks win over the magnitude flags so zero operands always terminate.
  always_comb begin
    ready  = (state == ST_IDLE);
    done   = (state == ST_DONE);
    load   = (state == ST_IDLE) && start;
    finish = (state == ST_CALC) && (a_zero || b_zero || eq);
    sub_a  = (state == ST_CALC) && !a_zero && !b_zero && gt;
    sub_b  = (state == ST_CALC) && !a_zero && !b_zero && lt;
  end

  always_ff @(posedge clk) begin
    if (rst)         result <= '0;
    else if (finish) result <= final_value;
  end

`ifdef GCD_ITER_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      iter_cnt <= '0;
    else if (load)
      iter_cnt <= '0;
    else if ((sub_a || sub_b) && (iter_cnt != {ITER_W{1'b1}}))
      iter_cnt <= iter_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_gcd_engine.sv
// tb/tb_gcd_engine.sv - randomized self-checking bench for gcd_engine against a Euclid reference.
// Iteration-count checks are compiled in with GCD_ITER_COUNT_EN.
module tb_gcd_engine;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        ready;
  logic        done;
  logic [15:0] result;
`ifdef GCD_ITER_COUNT_EN
  logic [15:0] iter_cnt;
`endif
  logic [15:0] last_iter;

  int errors = 0;
  int checks = 0;

  gcd_engine dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .ready  (ready),
    .done   (done),
    .result (result)
`ifdef GCD_ITER_COUNT_EN
    ,
    .iter_cnt (iter_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference: Euclid by division; subtraction count is the sum of quotients minus the final equal step.
  function automatic void model(input int a, input int b, output int g, output int n);
    int x, y, r, q;
    if (a == 0) begin
      g = b; n = 0;
    end else if (b == 0) begin
      g = a; n = 0;
    end else begin
      x = a; y = b; q = 0;
      while (y != 0) begin
        q = q + x / y;
        r = x % y;
        x = y;
        y = r;
      end
      g = x;
      n = q - 1;
    end
  endfunction

  // Launch one operation from IDLE; latency counts clock edges from the start edge to the edge that sees done.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int limit,
                        output int lat, output logic [15:0] res, output bit changed);
    logic [15:0] prev;
    lat = -1; res = 'x; changed = 0;
    @(negedge clk);
    prev = result;
    start = 1'b1; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom);
    for (int m = 0; m <= limit; m++) begin
      if (m > 0) @(negedge clk);
      if (done) begin
        lat = m + 1;
        res = result;
`ifdef GCD_ITER_COUNT_EN
        last_iter = iter_cnt;
`endif
        break;
      end
      if (result !== prev) changed = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (result !== 16'd0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result); end
`ifdef GCD_ITER_COUNT_EN
    checks++; if (iter_cnt !== 16'd0) begin errors++; $display("FAIL reset_iter: got %0d expected 0", iter_cnt); end
`endif
  endtask

  task automatic test_basic();
    int g, n, lat; logic [15:0] res; bit ch;
    model(48, 18, g, n);
    run_op(16'd48, 16'd18, 200, lat, res, ch);
    checks++; if (res !== 16'(g)) begin errors++; $display("FAIL basic_result: got %0d expected %0d", res, g); end
    checks++; if (lat !== n + 2) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, n + 2); end
`ifdef GCD_ITER_COUNT_EN
    checks++; if (last_iter !== 16'(n)) begin errors++; $display("FAIL basic_iter: got %0d expected %0d", last_iter, n); end
`endif
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after_done: got %0b expected 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %0b expected 0", done); end
    checks++; if (result !== 16'(g)) begin errors++; $display("FAIL basic_result_hold: got %0d expected %0d", result, g); end
  endtask

  task automatic test_zero_equal();
    logic [15:0] ta [4];
    logic [15:0] tb [4];
    int g, n, lat; logic [15:0] res; bit ch;
    ta = '{16'd12, 16'd0, 16'd35, 16'd0};
    tb = '{16'd12, 16'd35, 16'd0, 16'd0};
    for (int i = 0; i < 4; i++) begin
      model(int'(ta[i]), int'(tb[i]), g, n);
      run_op(ta[i], tb[i], 20, lat, res, ch);
      checks++; if (res !== 16'(g)) begin errors++; $display("FAIL zero_eq_result[%0d]: got %0d expected %0d", i, res, g); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL zero_eq_latency[%0d]: got %0d expected 2", i, lat); end
`ifdef GCD_ITER_COUNT_EN
      checks++; if (last_iter !== 16'd0) begin errors++; $display("FAIL zero_eq_iter[%0d]: got %0d expected 0", i, last_iter); end
`endif
    end
  endtask

  task automatic test_worst_case();
    int lat; logic [15:0] res; bit ch;
    run_op(16'hFFFF, 16'd1, 70000, lat, res, ch);
    checks++; if (res !== 16'd1) begin errors++; $display("FAIL worst_result: got %0d expected 1", res); end
    checks++; if (lat !== 65536) begin errors++; $display("FAIL worst_latency: got %0d expected 65536", lat); end
`ifdef GCD_ITER_COUNT_EN
    checks++; if (last_iter !== 16'hFFFE) begin errors++; $display("FAIL worst_iter: got %0h expected fffe", last_iter); end
`endif
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL worst_done_width: got %0b expected 0", done); end
  endtask

  // start stays high while operands change every cycle; the model predicts every acceptance edge.
  task automatic test_start_held();
    int next_acc, done_t, g, n, exp_g;
    bit exp_ready, exp_done;
    int wait_cnt;
    wait_cnt = 0;
    @(negedge clk);
    while (!ready && wait_cnt < 1000) begin @(negedge clk); wait_cnt++; end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL held_initial_ready: got %0b expected 1", ready); end
    next_acc = 0; done_t = -1; exp_g = 0;
    start = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (t > 0) @(negedge clk);
      exp_ready = (t == next_acc);
      exp_done  = (t == done_t);
      checks++; if (ready !== exp_ready) begin errors++; $display("FAIL held_ready@%0d: got %0b expected %0b", t, ready, exp_ready); end
      checks++; if (done !== exp_done) begin errors++; $display("FAIL held_done@%0d: got %0b expected %0b", t, done, exp_done); end
      if (exp_done) begin
        checks++; if (result !== 16'(exp_g)) begin errors++; $display("FAIL held_result@%0d: got %0d expected %0d", t, result, exp_g); end
      end
      a_in = 16'($urandom_range(0, 40));
      b_in = 16'($urandom_range(0, 40));
      if (t == next_acc) begin
        model(int'(a_in), int'(b_in), g, n);
        exp_g = g;
        done_t = t + n + 2;
        next_acc = t + n + 3;
      end
    end
    start = 1'b0;
    wait_cnt = 0;
    @(negedge clk);
    while (!ready && wait_cnt < 1000) begin @(negedge clk); wait_cnt++; end
  endtask

  task automatic test_reset_abort();
    int lat, g, n; logic [15:0] res; bit ch;
    bit saw_done;
    saw_done = 0;
    @(negedge clk);
    start = 1'b1; a_in = 16'd1000; b_in = 16'd7;
    @(negedge clk);
    start = 1'b0;
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_early_done: got %0b expected 0", saw_done); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %0b expected 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %0b expected 0", done); end
    checks++; if (result !== 16'd0) begin errors++; $display("FAIL abort_result: got %0d expected 0", result); end
    model(21, 14, g, n);
    run_op(16'd21, 16'd14, 200, lat, res, ch);
    checks++; if (res !== 16'(g)) begin errors++; $display("FAIL abort_next_result: got %0d expected %0d", res, g); end
    checks++; if (lat !== n + 2) begin errors++; $display("FAIL abort_next_latency: got %0d expected %0d", lat, n + 2); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, g1, n1, g2, n2; logic [15:0] r1, r2; bit ch1, ch2;
    model(9, 6, g1, n1);
    model(100, 75, g2, n2);
    run_op(16'd9, 16'd6, 200, lat1, r1, ch1);
    run_op(16'd100, 16'd75, 400, lat2, r2, ch2);
    checks++; if (r1 !== 16'(g1)) begin errors++; $display("FAIL b2b_result1: got %0d expected %0d", r1, g1); end
    checks++; if (lat1 !== n1 + 2) begin errors++; $display("FAIL b2b_latency1: got %0d expected %0d", lat1, n1 + 2); end
    checks++; if (r2 !== 16'(g2)) begin errors++; $display("FAIL b2b_result2: got %0d expected %0d", r2, g2); end
    checks++; if (lat2 !== n2 + 2) begin errors++; $display("FAIL b2b_latency2: got %0d expected %0d", lat2, n2 + 2); end
    checks++; if (ch2 !== 1'b0) begin errors++; $display("FAIL b2b_result_stable: got %0b expected 0", ch2); end
  endtask

  task automatic test_random();
    int g, n, lat; logic [15:0] a, b, res; bit ch;
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom_range(0, 255));
      b = 16'($urandom_range(0, 255));
      model(int'(a), int'(b), g, n);
      run_op(a, b, 600, lat, res, ch);
      checks++; if (res !== 16'(g)) begin errors++; $display("FAIL rand_result(%0d,%0d): got %0d expected %0d", a, b, res, g); end
      checks++; if (lat !== n + 2) begin errors++; $display("FAIL rand_latency(%0d,%0d): got %0d expected %0d", a, b, lat, n + 2); end
      checks++; if (ch !== 1'b0) begin errors++; $display("FAIL rand_result_hold(%0d,%0d): got %0b expected 0", a, b, ch); end
`ifdef GCD_ITER_COUNT_EN
      checks++; if (last_iter !== 16'(n)) begin errors++; $display("FAIL rand_iter(%0d,%0d): got %0d expected %0d", a, b, last_iter, n); end
`endif
    end
  endtask

  initial begin
    last_iter = '0;
    test_reset();
    test_basic();
    test_zero_equal();
    test_worst_case();
    test_start_held();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
